rx_frame_writer: RTL
====================

# rx_frame_writer

Receive packet buffer stage sitting directly downstream of the Rx packet scanner. Writes every strobed octet into an internal circular RAM, and commits or rolls back each frame when the scanner's end-of-frame status arrives. Committed frames are announced through a small descriptor FIFO to the response/transmit logic, which reads octets through a random-access read port and releases buffer space by popping descriptors.

## Interface

- `aw`, 11: buffer address width; RAM is 2^aw octets.
- `dw`, 2: descriptor FIFO address width; depth is 2^dw.
- `keep_mask`, 4'b1110: bit n set means commit frames whose `status_vec[1:0]==n`.

- `clk`  in  1  Rx clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `idata`  in  8  frame octet from scanner.
- `idata_s`  in  1  octet strobe; high for the contiguous duration of a frame.
- `idata_f`  in  1  marks the final strobed octet.
- `status_valid`  in  1  single-cycle pulse; per scanner contract, coincident with `idata_f`.
- `status_vec`  in  8  `{port[2:0], pass_ip, pass_mac, crc_ok, category[1:0]}`, valid with `status_valid`.
- `rd_addr`  in  aw  consumer read address, modulo 2^aw.
- `rd_data`  out  8  RAM octet at `rd_addr`, one-cycle latency.
- `desc_valid`  out  1  descriptor FIFO non-empty.
- `desc_addr`  out  aw  buffer address of the head frame's first octet.
- `desc_len`  out  11  head frame octet count, including CRC.
- `desc_status`  out  8  head frame `status_vec`.
- `desc_pop`  in  1  retire the head descriptor and free its space; ignored when `desc_valid` is 0.
- `drop_cnt`  out  8  saturating count of keep-eligible frames lost to overflow or a full FIFO.

## Operation

- Pointers, all aw bits and modulo 2^aw:
  - `wp`: write pointer.
  - `sp`: start of the current frame.
  - `fp`: free pointer.
  - `used = wp - fp`.
- States: IDLE, RECV, DISCARD.
  - IDLE: when `idata_s` is high, set `sp <= wp`, write the octet, set `len <= 1`, go to RECV. If buffer is full (`used == 2^aw-1`), go to DISCARD instead.
  - RECV, each strobed octet:
    - If `used == 2^aw-1`, do not write, set `ovf`, go to DISCARD.
    - Otherwise write at `wp`, increment `wp` and `len`.
  - RECV with `status_valid` (the final octet is written this cycle):
    - `keep = keep_mask[status_vec[1:0]]`.
    - Commit if `keep` is true and the FIFO is not full (after accounting for a same-cycle pop). Commit pushes `{sp, len, status_vec}` and leaves `wp` past the frame.
    - Otherwise roll back: `wp <= sp`. If `keep` was true, increment `drop_cnt`.
    - Go to IDLE.
  - RECV, `idata_s` falls without `status_valid` (aborted frame): roll back, go to IDLE, no count.
  - DISCARD:
    - Write nothing; `wp <= sp` on entry.
    - On `status_valid` or an `idata_s` low cycle, go to IDLE.
    - Increment `drop_cnt` if `status_valid` arrived with `keep` true.
- Frames longer than 2^aw-1 octets always overflow.
- `len` saturates at 2047.
- `desc_pop`: `fp <= fp + desc_len` (modulo 2^aw), FIFO read pointer increments.
- Frames may wrap past address 2^aw-1; the consumer forms its addresses modulo 2^aw.
- `drop_cnt` saturates at 255.
- Reset values:
  - Pointers 0, FIFO empty, state IDLE.
  - `desc_valid`, `desc_addr`, `desc_len`, `desc_status`, `drop_cnt`, `rd_data` all 0.
- Reset mid-frame discards the frame; a new frame is accepted only at the next rising edge of `idata_s` after reset.

## Timing

- RAM write occurs in the same cycle as the strobed octet.
- Read: `rd_data` is valid one cycle after `rd_addr`. Read-during-write to the same address returns old data.
- `desc_valid` rises, with all `desc_*` stable, on the cycle after the commit cycle (the `status_valid` cycle).
- `desc_pop` sampled high:
  - The next descriptor, or `desc_valid=0`, appears the following cycle.
  - `fp` updates the following cycle.
  - The space check uses the pre-pop `fp`, which is conservative.
- Commit and pop in the same cycle with the FIFO full: both take effect; the commit succeeds.
- Minimum gap between frames: one `idata_s` low cycle. IDLE re-enters RECV the cycle after a commit or rollback.
- Maximum occupancy is 2^aw-1 octets. One slot is always kept empty, so `used` is unambiguous.

## Test plan

- Single 64-octet frame, `status_vec=8'h07`:
  - Next cycle: `desc_valid=1`, `desc_addr=0`, `desc_len=64`, `desc_status=8'h07`.
  - Reading addresses 0..63 returns the stimulus octets one cycle after each address.
- 64-octet frame with `status_vec[1:0]=0`: no descriptor; next frame lands at `desc_addr=0`; `drop_cnt` stays 0.
- With `aw=8`, push a 200-octet frame, pop it, push a 100-octet frame:
  - Second descriptor has `desc_addr=200`.
  - Its data wraps, addresses 200..255 then 0..43, and reads back correctly.
- With `aw=8`, push a 300-octet kept frame: no descriptor, `drop_cnt=1`, `wp` returns to `sp`; a following 60-octet frame commits normally.
- With `dw=1`, commit two frames and do not pop: a third kept frame is dropped with `drop_cnt=1`. Repeat with `desc_pop` coincident with the third `status_valid`: the third frame commits.
- Assert `rst_n` low mid-frame: all outputs read 0 and `desc_valid=0`; the next full frame commits at address 0.

Source files
------------

// File: rtl/rx_frame_writer.sv
// ============================================================================
// rx_frame_writer : circular Rx octet buffer with commit/rollback and descriptor FIFO
// Revision: 1.0
// ============================================================================
`default_nettype none

module rx_frame_writer #(
  parameter int         AW        = 11,
  parameter int         DW        = 2,
  parameter logic [3:0] KEEP_MASK = 4'b1110
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    i_idata,
  input  logic          i_idata_s,
  input  logic          i_idata_f,
  input  logic          i_status_valid,
  input  logic [7:0]    i_status_vec,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  output logic          o_desc_valid,
  output logic [AW-1:0] o_desc_addr,
  output logic [10:0]   o_desc_len,
  output logic [7:0]    o_desc_status,
  input  logic          i_desc_pop,
  output logic [7:0]    o_drop_cnt
);

  localparam int          c_RAM     = 1 << AW;
  localparam int          c_DEPTH   = 1 << DW;
  localparam logic [1:0]  c_IDLE    = 2'd0;
  localparam logic [1:0]  c_RECV    = 2'd1;
  localparam logic [1:0]  c_DISC    = 2'd2;
  localparam logic [AW-1:0] c_FULL  = '1;
  localparam logic [10:0] c_LEN_MAX = 11'd2047;

  logic [1:0]    r_state, w_next;
  logic [AW-1:0] r_wp, r_sp, r_fp;
  logic [10:0]   r_len;
  logic          r_s_d;
  logic [7:0]    r_mem [c_RAM];
  logic [7:0]    r_rd_data;
  logic [AW-1:0] r_qa [c_DEPTH];
  logic [10:0]   r_ql [c_DEPTH];
  logic [7:0]    r_qs [c_DEPTH];
  logic [DW-1:0] r_qwr, r_qrd;
  logic [DW:0]   r_qcnt;
  logic [7:0]    r_drop;

  logic          w_full, w_start, w_in, w_octet, w_eof, w_keep, w_pop, w_qok;
  logic [AW-1:0] w_base;
  logic [10:0]   w_len;
  logic          w_we, w_commit, w_rollback, w_drop;

  assign w_full  = (r_wp - r_fp) == c_FULL;
  // r_s_d resets high so a frame already in flight at reset is never picked up
  assign w_start = (r_state == c_IDLE) && i_idata_s && !r_s_d;
  assign w_in    = (r_state == c_RECV) && i_idata_s;
  assign w_octet = w_start || w_in;
  assign w_eof   = i_status_valid && i_idata_f;
  assign w_keep  = KEEP_MASK[i_status_vec[1:0]];
  assign w_pop   = i_desc_pop && (r_qcnt != '0);
  assign w_qok   = (r_qcnt != (DW+1)'(c_DEPTH)) || w_pop;
  assign w_base  = w_start ? r_wp : r_sp;
  assign w_len   = w_start ? 11'd1 : ((r_len == c_LEN_MAX) ? r_len : r_len + 11'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: if (w_start) w_next = w_eof ? c_IDLE : (w_full ? c_DISC : c_RECV);
      c_RECV: begin
        if (!i_idata_s || w_eof) w_next = c_IDLE;
        else if (w_full)         w_next = c_DISC;
      end
      c_DISC: if (w_eof || !i_idata_s) w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_we       = w_octet && !w_full;
    w_commit   = w_we && w_eof && w_keep && w_qok;
    w_rollback = (w_octet && (w_full || (w_eof && !w_commit))) ||
                 ((r_state == c_RECV) && !i_idata_s);
    w_drop     = w_eof && w_keep && ((w_octet && !w_commit) || (r_state == c_DISC));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp      <= '0;
      r_sp      <= '0;
      r_fp      <= '0;
      r_len     <= '0;
      r_s_d     <= 1'b1;
      r_qwr     <= '0;
      r_qrd     <= '0;
      r_qcnt    <= '0;
      r_drop    <= '0;
      r_rd_data <= '0;
    end else begin
      r_s_d     <= i_idata_s;
      r_rd_data <= r_mem[i_rd_addr];
      if (w_start) r_sp <= r_wp;
      if (w_octet) r_len <= w_len;
      if (w_rollback)  r_wp <= w_base;
      else if (w_we)   r_wp <= r_wp + 1'b1;
      if (w_pop) begin
        r_fp  <= r_fp + AW'(r_ql[r_qrd]);
        r_qrd <= r_qrd + 1'b1;
      end
      if (w_commit) r_qwr <= r_qwr + 1'b1;
      case ({w_commit, w_pop})
        2'b10:   r_qcnt <= r_qcnt + 1'b1;
        2'b01:   r_qcnt <= r_qcnt - 1'b1;
        default: r_qcnt <= r_qcnt;
      endcase
      if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wp] <= i_idata;
    if (w_commit) begin
      r_qa[r_qwr] <= w_base;
      r_ql[r_qwr] <= w_len;
      r_qs[r_qwr] <= i_status_vec;
    end
  end

  assign o_rd_data     = r_rd_data;
  assign o_desc_valid  = (r_qcnt != '0);
  assign o_desc_addr   = o_desc_valid ? r_qa[r_qrd] : '0;
  assign o_desc_len    = o_desc_valid ? r_ql[r_qrd] : '0;
  assign o_desc_status = o_desc_valid ? r_qs[r_qrd] : '0;
  assign o_drop_cnt    = r_drop;

endmodule

`default_nettype wire
